// File: rtl/drive_cmd_rx_if.sv
// drive_cmd_rx_if: remote-link bundle; rxd into the receiver, decoded drive/steer codes and status pulses out
interface drive_cmd_rx_if;
  logic       rxd;
  logic [1:0] drive;
  logic [1:0] steer;
  logic       cmd_valid;
  logic       frame_err;
  logic       link_ok;
  modport master (input rxd, output drive, steer, cmd_valid, frame_err, link_ok);
  modport slave (output rxd, input drive, steer, cmd_valid, frame_err, link_ok);
endinterface

// File: rtl/drive_cmd_rx.sv
// drive_cmd_rx: 8N1 UART command receiver with link watchdog; ports clk, rst (sync high), bus.master (rxd in; drive, steer, cmd_valid, frame_err, link_ok out)
module drive_cmd_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 500
) (
  input  logic          clk,
  input  logic          rst,
  drive_cmd_rx_if.master bus
);
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int TO_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int BW     = $clog2(DIV);
  localparam int WW     = $clog2(TO_CYC);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t st, st_n;
  logic [1:0] sync;
  logic rxd_s, rxd_p;
  logic [BW-1:0] cnt, cnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] sh, sh_n, ch;
  logic [WW-1:0] wd;
  logic done, ferr, is_f, is_b, is_s, is_l, is_r, is_c, hit, timeout;
  assign rxd_s = sync[1];
  always_comb begin
    st_n   = st;
    cnt_n  = cnt + 1'b1;
    bcnt_n = bcnt;
    sh_n   = sh;
    done   = 1'b0;
    ferr   = 1'b0;
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (rxd_p && !rxd_s) begin
          st_n   = START;
          bcnt_n = '0;
        end
      end
      START: if (cnt == BW'(DIV / 2 - 1)) begin
        cnt_n = '0;
        st_n  = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt == BW'(DIV - 1)) begin
        cnt_n  = '0;
        sh_n   = {rxd_s, sh[7:1]};
        bcnt_n = bcnt + 3'd1;
        st_n   = (bcnt == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == BW'(DIV - 1)) begin
        cnt_n = '0;
        done  = rxd_s;
        ferr  = !rxd_s;
        st_n  = rxd_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        st_n  = rxd_s ? IDLE : WAIT_IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
  assign ch      = sh & 8'hDF;
  assign is_f    = ch == 8'h46;
  assign is_b    = ch == 8'h42;
  assign is_s    = ch == 8'h53;
  assign is_l    = ch == 8'h4C;
  assign is_r    = ch == 8'h52;
  assign is_c    = ch == 8'h43;
  assign hit     = done && (is_f || is_b || is_s || is_l || is_r || is_c);
  assign timeout = bus.link_ok && (wd == WW'(TO_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      rxd_p         <= 1'b1;
      st            <= IDLE;
      cnt           <= '0;
      bcnt          <= '0;
      sh            <= '0;
      wd            <= '0;
      bus.drive     <= 2'b00;
      bus.steer     <= 2'b00;
      bus.cmd_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.link_ok   <= 1'b0;
    end else begin
      sync          <= {sync[0], bus.rxd};
      rxd_p         <= rxd_s;
      st            <= st_n;
      cnt           <= cnt_n;
      bcnt          <= bcnt_n;
      sh            <= sh_n;
      bus.cmd_valid <= hit;
      bus.frame_err <= ferr;
      // a command landing on the timeout cycle takes priority over the watchdog
      if (hit) begin
        bus.drive   <= is_f ? 2'b10 : is_b ? 2'b01 : is_s ? 2'b00 : bus.drive;
        bus.steer   <= is_l ? 2'b10 : is_r ? 2'b01 : (is_s || is_c) ? 2'b00 : bus.steer;
        bus.link_ok <= 1'b1;
        wd          <= '0;
      end else if (timeout) begin
        bus.drive   <= 2'b00;
        bus.steer   <= 2'b00;
        bus.link_ok <= 1'b0;
        wd          <= '0;
      end else if (bus.link_ok) begin
        wd <= wd + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_drive_cmd_rx.sv
// tb_drive_cmd_rx: directed self-checking bench for drive_cmd_rx at DIV = 10, TO_CYC = 1000
module tb_drive_cmd_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0, fails = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, n_bad = 0, v_cyc = 0, last_start = 0;
  logic pv = 1'b0, pf = 1'b0;
  drive_cmd_rx_if bus ();
  drive_cmd_rx #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_MS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // sees the values registered by the previous edge; v_cyc matches the cyc seen at the negedge the pulse was high
  always @(posedge clk) begin
    if (bus.cmd_valid) begin
      n_valid = n_valid + 1;
      v_cyc = cyc;
    end
    if (bus.frame_err) n_ferr = n_ferr + 1;
    if ((bus.cmd_valid && bus.frame_err) || (bus.cmd_valid && pv) || (bus.frame_err && pf)) n_bad = n_bad + 1;
    pv = bus.cmd_valid;
    pf = bus.frame_err;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d want finish", cyc);
    $fatal(1, "bench timed out");
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      bus.rxd = f[i];
      repeat (10) @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.drive !== 2'b00) begin fails++; $display("FAIL reset_drive got %b want 00", bus.drive); end
    tests++; if (bus.steer !== 2'b00) begin fails++; $display("FAIL reset_steer got %b want 00", bus.steer); end
    tests++; if ({bus.cmd_valid, bus.frame_err, bus.link_ok} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {bus.cmd_valid, bus.frame_err, bus.link_ok}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_forward();
    int n0;
    n0 = n_valid;
    send_byte(8'h46, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (n_valid - n0 !== 1) begin fails++; $display("FAIL fwd_pulses got %0d want 1", n_valid - n0); end
    tests++; if (v_cyc - last_start !== 98) begin fails++; $display("FAIL fwd_latency got %0d want 98", v_cyc - last_start); end
    tests++; if (bus.drive !== 2'b10) begin fails++; $display("FAIL fwd_drive got %b want 10", bus.drive); end
    tests++; if (bus.steer !== 2'b00) begin fails++; $display("FAIL fwd_steer got %b want 00", bus.steer); end
    tests++; if (bus.link_ok !== 1'b1) begin fails++; $display("FAIL fwd_link got %b want 1", bus.link_ok); end
  endtask
  task automatic test_back_to_back();
    int n0;
    n0 = n_valid;
    send_byte(8'h6C, 1'b1);
    tests++; if ({bus.drive, bus.steer} !== 4'b1010) begin fails++; $display("FAIL b2b_l got %b want 1010", {bus.drive, bus.steer}); end
    send_byte(8'h62, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if ({bus.drive, bus.steer} !== 4'b0110) begin fails++; $display("FAIL b2b_b got %b want 0110", {bus.drive, bus.steer}); end
    tests++; if (n_valid - n0 !== 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", n_valid - n0); end
  endtask
  task automatic test_bad_bytes();
    int n0, f0;
    n0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h41, 1'b1);
    repeat (3) @(negedge clk);
    tests++; if (n_valid !== n0) begin fails++; $display("FAIL unk_pulse got %0d want %0d", n_valid, n0); end
    tests++; if ({bus.drive, bus.steer} !== 4'b0110) begin fails++; $display("FAIL unk_out got %b want 0110", {bus.drive, bus.steer}); end
    send_byte(8'h46, 1'b0);
    repeat (200) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - f0); end
    tests++; if (n_valid !== n0) begin fails++; $display("FAIL ferr_valid got %0d want %0d", n_valid, n0); end
    tests++; if ({bus.drive, bus.steer} !== 4'b0110) begin fails++; $display("FAIL ferr_out got %b want 0110", {bus.drive, bus.steer}); end
    send_byte(8'h53, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if ({bus.drive, bus.steer} !== 4'b0000) begin fails++; $display("FAIL stop_out got %b want 0000", {bus.drive, bus.steer}); end
  endtask
  task automatic test_glitch();
    int n0, f0;
    n0 = n_valid;
    f0 = n_ferr;
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (50) @(negedge clk);
    tests++; if (n_valid !== n0 || n_ferr !== f0) begin fails++; $display("FAIL glitch_pulses got %0d/%0d want %0d/%0d", n_valid, n_ferr, n0, f0); end
    send_byte(8'h4C, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (n_valid - n0 !== 1) begin fails++; $display("FAIL glitch_after got %0d want 1", n_valid - n0); end
    tests++; if ({bus.drive, bus.steer} !== 4'b0010) begin fails++; $display("FAIL glitch_out got %b want 0010", {bus.drive, bus.steer}); end
  endtask
  task automatic test_watchdog();
    int v, v2;
    send_byte(8'h46, 1'b1);
    v = last_start + 98;
    while (cyc < v + 999) @(negedge clk);
    tests++; if ({bus.link_ok, bus.drive} !== 3'b110) begin fails++; $display("FAIL wd_before got %b want 110", {bus.link_ok, bus.drive}); end
    @(negedge clk);
    tests++; if ({bus.link_ok, bus.drive, bus.steer} !== 5'b00000) begin fails++; $display("FAIL wd_expire got %b want 00000", {bus.link_ok, bus.drive, bus.steer}); end
    send_byte(8'h46, 1'b1);
    v2 = last_start + 98;
    while (cyc < v2 + 902) @(negedge clk);
    fork
      send_byte(8'h52, 1'b1);
      begin
        while (cyc < v2 + 1000) @(negedge clk);
        tests++; if ({bus.cmd_valid, bus.link_ok, bus.drive, bus.steer} !== 6'b111001) begin fails++; $display("FAIL wd_race got %b want 111001", {bus.cmd_valid, bus.link_ok, bus.drive, bus.steer}); end
        @(negedge clk);
        tests++; if (bus.link_ok !== 1'b1) begin fails++; $display("FAIL wd_race_hold got %b want 1", bus.link_ok); end
      end
    join
  endtask
  task automatic test_reset_mid_frame();
    int n0, f0;
    send_byte(8'h42, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (bus.drive !== 2'b01) begin fails++; $display("FAIL mid_pre got %b want 01", bus.drive); end
    n0 = n_valid;
    f0 = n_ferr;
    fork
      send_byte(8'h46, 1'b1);
      begin
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if ({bus.drive, bus.steer, bus.link_ok} !== 5'b00000) begin fails++; $display("FAIL mid_reset got %b want 00000", {bus.drive, bus.steer, bus.link_ok}); end
      end
    join
    repeat (200) @(negedge clk);
    tests++; if (n_valid !== n0 || n_ferr !== f0) begin fails++; $display("FAIL mid_pulses got %0d/%0d want %0d/%0d", n_valid, n_ferr, n0, f0); end
  endtask
  initial begin
    bus.rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_back_to_back();
    test_bad_bytes();
    test_glitch();
    test_watchdog();
    test_reset_mid_frame();
    tests++; if (n_bad !== 0) begin fails++; $display("FAIL pulse_rules got %0d want 0", n_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
